// File: rtl/alu_exec_stage.sv
// Execute stage around a combinational ALU.
// S0 holds the accepted operation and drives the ALU directly; S1 captures the
// ALU result for writeback. Architectural Z/N/V flags track retired results.
//
// Handshake rule on both sides: a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and payload steady
// until that edge. A consumer may drive ready independently of valid.

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADD
`define ADD 5'h00
`endif
`ifndef SUB
`define SUB 5'h01
`endif

module alu_exec_stage #(
  parameter int DATA_W = `WORD_SIZE,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_overflow,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_overflow,
  output logic              wb_illegal,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  input  logic              clr_flags
);

  logic            s0_v;
  logic            s1_v;
  logic [RD_W-1:0] s0_rd;
  logic            s1_adv;
  logic            in_fire;
  logic            wb_fire;
  logic            op_legal;

  // S0 moves into S1 whenever S1 is empty or is being drained this cycle.
  assign s1_adv   = s0_v && (!s1_v || wb_ready);
  assign in_ready = !s0_v || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign wb_valid = s1_v;
  assign wb_fire  = s1_v && wb_ready;
  assign op_legal = (alu_opcode == `ADD) || (alu_opcode == `SUB);

  // Operand register: load on accept, drain into S1, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      s0_rd      <= '0;
    end else begin
      if (in_fire) begin
        s0_v       <= 1'b1;
        alu_a      <= in_a;
        alu_b      <= in_b;
        alu_opcode <= in_opcode;
        s0_rd      <= in_rd;
      end else if (s1_adv) begin
        s0_v <= 1'b0;
      end
    end
  end

  // Result register: capture ALU output (or an illegal marker) from S0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v        <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_overflow <= 1'b0;
      wb_illegal  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v        <= 1'b1;
        wb_rd       <= s0_rd;
        wb_data     <= op_legal ? alu_c : '0;
        wb_overflow <= op_legal ? alu_overflow : 1'b0;
        wb_illegal  <= !op_legal;
      end else if (wb_fire) begin
        s1_v <= 1'b0;
      end
    end
  end

  // Status flags follow retired results; an overflow retiring beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      if (wb_fire) begin
        flag_z <= (wb_data == '0);
        flag_n <= wb_data[DATA_W-1];
      end
      flag_v <= (flag_v && !clr_flags) || (wb_fire && wb_overflow);
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a bench-side ALU, a transaction-level model of
// the stage (ordered queue plus flag state) checked every cycle, and directed
// operations carrying hand-computed results.

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADD
`define ADD 5'h00
`endif
`ifndef SUB
`define SUB 5'h01
`endif

module tb_alu_exec_stage;

  localparam int DW = 8;
  localparam int RW = 3;
  localparam logic [4:0] OP_ILL = 5'h1F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_opcode = '0;
  logic [RW-1:0] in_rd = '0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [4:0]    alu_opcode;
  logic          alu_overflow;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_overflow, wb_illegal;
  logic          flag_z, flag_n, flag_v;
  logic          clr_flags = 1'b0;

  alu_exec_stage #(.DATA_W(DW), .RD_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_overflow(wb_overflow), .wb_illegal(wb_illegal),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .clr_flags(clr_flags)
  );

  // Bench ALU; for unknown opcodes it returns junk the stage must ignore.
  always_comb begin
    alu_c = 8'hAA;
    alu_overflow = 1'b1;
    if (alu_opcode == `ADD) begin
      alu_c = alu_a + alu_b;
      alu_overflow = (alu_a[7] == alu_b[7]) && (alu_c[7] != alu_a[7]);
    end else if (alu_opcode == `SUB) begin
      alu_c = alu_a - alu_b;
      alu_overflow = (alu_a[7] != alu_b[7]) && (alu_c[7] != alu_a[7]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic started = 1'b0;

  // {illegal, overflow, rd, data}
  logic [12:0] exp_q[$];
  int          tag_q[$];
  // {check, data, overflow, illegal} hand-computed per accepted op
  logic [10:0] lit_q[$];
  logic m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] model(input logic [4:0] op, input logic [RW-1:0] rd,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    int r;
    logic [DW-1:0] d;
    logic ov;
    if (op == `ADD) r = int'($signed(a)) + int'($signed(b));
    else if (op == `SUB) r = int'($signed(a)) - int'($signed(b));
    else return {1'b1, 1'b0, rd, 8'h00};
    ov = (r > 127) || (r < -128);
    d = r[7:0];
    return {1'b0, ov, rd, d};
  endfunction

  logic [12:0] hd;
  logic [10:0] lt;
  logic        e_valid, in_fire_m, wb_fire_m;

  // Compare outputs against the model, then advance the model over the next edge.
  always @(negedge clk) begin
    if (started) begin
      e_valid = (exp_q.size() > 0) && (cyc >= tag_q[0] + 1);
      chk("wb_valid", wb_valid, e_valid);
      chk("in_ready", in_ready, (exp_q.size() < 2) || wb_ready);
      chk("flag_z", flag_z, m_z);
      chk("flag_n", flag_n, m_n);
      chk("flag_v", flag_v, m_v);
      if (e_valid) begin
        hd = exp_q[0];
        chk("wb_rd", wb_rd, hd[10:8]);
        chk("wb_data", wb_data, hd[7:0]);
        chk("wb_overflow", wb_overflow, hd[11]);
        chk("wb_illegal", wb_illegal, hd[12]);
      end
      if (rst) begin
        exp_q.delete(); tag_q.delete(); lit_q.delete();
        m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
      end else begin
        wb_fire_m = e_valid && wb_ready;
        in_fire_m = in_valid && in_ready;
        m_v = m_v && !clr_flags;
        if (wb_fire_m) begin
          hd = exp_q.pop_front();
          void'(tag_q.pop_front());
          m_z = (hd[7:0] == 8'h00);
          m_n = hd[7];
          if (hd[11]) m_v = 1'b1;
          if (lit_q.size() > 0) begin
            lt = lit_q.pop_front();
            if (lt[10]) begin
              chk("lit_data", hd[7:0], lt[9:2]);
              chk("lit_overflow", hd[11], lt[1]);
              chk("lit_illegal", hd[12], lt[0]);
            end
          end
        end
        if (in_fire_m) begin
          exp_q.push_back(model(in_opcode, in_rd, in_a, in_b));
          tag_q.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] op, input logic [RW-1:0] rd,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic c, input logic [DW-1:0] ed, input logic eo, input logic ei);
    int n;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_a = a; in_b = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_timeout", 0, 1);
    else lit_q.push_back({c, ed, eo, ei});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  int c0;

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {flag_z, flag_n, flag_v}, 0);
    chk("rst_alu_regs", {alu_a, alu_b, alu_opcode}, 0);

    // back-to-back add/sub
    issue(`ADD, 3'd1, 8'd5, 8'd3, 1, 8'd8, 0, 0);
    issue(`SUB, 3'd2, 8'd5, 8'd3, 1, 8'd2, 0, 0);
    drain();
    chk("t1_flags", {flag_z, flag_n, flag_v}, 3'b000);

    // signed overflow both directions
    issue(`ADD, 3'd3, 8'd100, 8'd50, 1, 8'h96, 1, 0);
    drain();
    chk("t2_n_v", {flag_n, flag_v}, 2'b11);
    issue(`SUB, 3'd4, 8'h80, 8'd1, 1, 8'h7F, 1, 0);
    drain();
    chk("t2_sticky_v", {flag_n, flag_v}, 2'b01);

    // zero result, clear, then clear colliding with an overflow retire
    issue(`SUB, 3'd5, 8'd7, 8'd7, 1, 8'd0, 0, 0);
    drain();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    chk("t3_clr", {flag_z, flag_v}, 2'b10);
    clr_flags = 1'b1;
    issue(`ADD, 3'd6, 8'd100, 8'd50, 1, 8'h96, 1, 0);
    drain();
    chk("t3_set_wins", flag_v, 1);
    clr_flags = 1'b0;

    // illegal opcode then a legal one
    issue(OP_ILL, 3'd7, 8'd9, 8'd9, 1, 8'd0, 0, 1);
    drain();
    chk("t4_ill_z", {flag_z, flag_n}, 2'b10);
    issue(`ADD, 3'd0, 8'd1, 8'd1, 1, 8'd2, 0, 0);
    drain();

    // backpressure: fill the stage, then release
    wb_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          logic [7:0] v;
          v = 8'(i);
          issue(`ADD, 3'(i), v, 8'd0, 1, v, 0, 0);
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("t5_full_in_ready", in_ready, 0);
        chk("t5_held_rd", wb_rd, 3'd1);
        wb_ready = 1'b1;
        c0 = cyc;
      end
    join
    drain();
    chk("t5_drain_cycles", cyc - c0, 4);

    // reset with both stages occupied
    wb_ready = 1'b0;
    issue(`ADD, 3'd5, 8'd1, 8'd1, 0, 8'd0, 0, 0);
    issue(`ADD, 3'd6, 8'd2, 8'd2, 0, 8'd0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_wb_valid", wb_valid, 0);
    chk("t6_flags", {flag_z, flag_n, flag_v}, 0);
    chk("t6_in_ready", in_ready, 1);
    wb_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    issue(`ADD, 3'd2, 8'd2, 8'd2, 1, 8'd4, 0, 0);
    drain();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage wrapper around the ALU.
- Accepts decoded operations from the decode/operand-fetch stage over a valid/ready handshake and registers the operands, which drive the ALU combinationally.
- Captures the ALU result and overflow into an output register for the writeback stage.
- Two-entry pipeline (operand register S0, result register S1) with full-throughput backpressure, plus architectural status flags (Z, N, sticky V).

Parameters:
- DATA_W, `WORD_SIZE, operand/result width; must equal the ALU width.
- RD_W, 3, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an operation.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  5  operation code (`ADD, `SUB from top macro header).
- in_rd  in  RD_W  destination register index.
- in_a  in  DATA_W  signed operand A.
- in_b  in  DATA_W  signed operand B.
- alu_a  out  DATA_W  to ALU operand a (S0 register).
- alu_b  out  DATA_W  to ALU operand b (S0 register).
- alu_opcode  out  5  to ALU opcode (S0 register).
- alu_c  in  DATA_W  ALU result.
- alu_overflow  in  1  ALU overflow.
- wb_valid  out  1  result available to writeback.
- wb_ready  in  1  writeback accepts.
- wb_rd  out  RD_W  destination index.
- wb_data  out  DATA_W  result.
- wb_overflow  out  1  this result overflowed.
- wb_illegal  out  1  opcode was not `ADD/`SUB.
- flag_z  out  1  last retired result == 0.
- flag_n  out  1  last retired result MSB.
- flag_v  out  1  sticky overflow.
- clr_flags  in  1  clear flag_v.

Behaviour:
- Reset (rst=1 at edge): S0/S1 valid bits cleared. All data registers, including alu_a, alu_b and alu_opcode, reset to 0. wb_valid, wb_overflow, wb_illegal, flag_z, flag_n and flag_v reset to 0. Reset overrides all handshakes and aborts in-flight ops; they are discarded, never retired.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - wb_valid and the wb_* payload stay stable until wb_ready.
  - in_ready is combinational: in_ready = !s0_v || s1_adv, where s1_adv = s0_v && (!s1_v || wb_ready).
- S0 (operand register):
  - Loads in_opcode/in_rd/in_a/in_b on input transfer.
  - Holds its contents while stalled.
  - Its registers are the alu_* outputs.
- S1 (result register):
  - On s1_adv, loads wb_rd, plus wb_data/wb_overflow/wb_illegal, computed from S0 as follows:
    - Opcode is `ADD or `SUB: wb_data = alu_c, wb_overflow = alu_overflow, wb_illegal = 0.
    - Any other opcode: wb_data = 0, wb_overflow = 0, wb_illegal = 1, and alu_c is ignored.
  - S1 stays valid if a new op advances the same cycle wb takes the old one; otherwise it clears on wb transfer.
- Latency: an op accepted at edge N shows wb_valid after edge N+1 (2 cycles). Throughput is one op/cycle with wb_ready held high.
- Ordering: strictly in order; no op is dropped or duplicated under any stall pattern.
- Full: with S0 and S1 both valid and wb_ready=0, in_ready=0. When wb_ready rises, in_ready rises in the same cycle.
- Flags update only on wb transfer (wb_valid && wb_ready):
  - flag_z = (wb_data == 0).
  - flag_n = wb_data[DATA_W-1].
  - flag_v |= wb_overflow.
  - Illegal ops update Z/N (data 0 gives Z=1, N=0).
- clr_flags clears flag_v at the edge. If clr_flags coincides with a retiring overflow, set wins and flag_v = 1.

Test Plan:
- DATA_W=8, wb_ready=1, issue ADD 5,3 then SUB 5,3 back-to-back -> wb_data 8 then 2 on consecutive cycles, each 2 cycles after acceptance, wb_overflow=0, flag_z=0.
- ADD 100,50 -> wb_data 0x96 (-106), wb_overflow=1, flag_n=1, flag_v=1. Then SUB -128,1 -> wb_data 0x7F, wb_overflow=1, flag_v stays 1.
- SUB 7,7 then clr_flags pulsed on a non-overflow cycle -> flag_z=1, flag_v=0. clr_flags asserted on the same edge an overflowing op retires -> flag_v=1.
- Opcode 5'h1F with a=9, b=9 -> wb_data 0, wb_illegal=1, wb_overflow=0, flag_z=1. The following ADD 1,1 -> 2, wb_illegal=0.
- wb_ready=0 while issuing ops 1..4 every cycle -> in_ready drops after 2 accepted, payload stable. Release wb_ready -> results retire in order 1..4 with no gap beyond one cycle per op.
- rst asserted for one cycle with S0 and S1 both full -> next cycle wb_valid=0, all flags 0, in_ready=1. Squashed ops never appear on wb.
